// File: rtl/multicycle_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB control sequencer with a bounded memory-wait
// timer, a saturating retire counter and sticky illegal/timeout/done flags.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IF    | instruction fetch, waits for mem_ready (ir_we on ready)
//   ID    | decode, one cycle
//   EX    | execute; branch/jump/illegal opcodes retire here
//   MEM   | data access (lw read / sw write), waits for mem_ready
//   WB    | register-file write, always retires
//   HALT  | absorbing end state, left only through reset
module multicycle_sequencer #(
    parameter int PROG_LEN = 11,
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [7:0]  pc,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [15:0] instr_count,
    output logic        illegal,
    output logic        mem_timeout,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [8:0] PROG_LEN_W = 9'(PROG_LEN);
    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_MAX - 1);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        done_q, done_d;

    logic        active;
    logic        retire;
    logic        op_wb, op_mem, op_branch, is_sw;

    // Strobes are also dropped while reset is asserted, so an access in
    // flight is cut in the same cycle rather than at the next edge.
    assign active    = run & reset_n;
    assign op_wb     = (opcode == OP_R)   || (opcode == OP_ADDI);
    assign op_mem    = (opcode == OP_LW)  || (opcode == OP_SW);
    assign op_branch = (opcode == OP_BEQ) || (opcode == OP_J);
    assign is_sw     = (opcode == OP_SW);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        done_d    = done_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;

        if (active) begin
            case (state_q)
                S_IF: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_ID;
                    end else if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
                S_ID: state_d = S_EX;
                S_EX: begin
                    if (op_wb) begin
                        state_d = S_WB;
                    end else if (op_mem) begin
                        state_d = S_MEM;
                        wait_d  = 4'd0;
                    end else begin
                        retire = 1'b1;
                        if (!op_branch) illegal_d = 1'b1;
                    end
                end
                S_MEM: begin
                    // Anything that is not a store is treated as a load, so
                    // read and write can never be raised together.
                    mem_sel = 1'b1;
                    mem_we  = is_sw;
                    mem_re  = !is_sw;
                    if (mem_ready) begin
                        if (is_sw) retire = 1'b1;
                        else       state_d = S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase

            if (retire) begin
                pc_we = 1'b1;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                if ({1'b0, pc} < PROG_LEN_W) begin
                    state_d = S_IF;
                    wait_d  = 4'd0;
                end else begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IF;
            wait_q    <= 4'd0;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign done        = done_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table for a
// short program, plus hand sequences for timeouts, run stalls and resets.
module tb_multicycle_sequencer;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    logic        clk = 1'b0;
    logic        reset_n, run, mem_ready;
    logic [5:0]  opcode;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        mem_re, mem_we, mem_sel, ir_we, pc_we, rf_we;
    logic [15:0] instr_count;
    logic        illegal, mem_timeout, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .pc(pc),
        .mem_ready(mem_ready), .state(state), .mem_re(mem_re), .mem_we(mem_we),
        .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .instr_count(instr_count), .illegal(illegal),
        .mem_timeout(mem_timeout), .done(done)
    );

    // strobes: {mem_re, mem_we, mem_sel, ir_we, pc_we, rf_we}
    // flags:   {illegal, mem_timeout, done}
    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic [7:0]  pc;
        logic        rdy;
        logic [2:0]  st;
        logic [5:0]  strb;
        logic [2:0]  flg;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [27:0] pack(input logic [2:0] st, input logic [5:0] strb,
                                         input logic [2:0] flg, input logic [15:0] cnt);
        return {st, strb, flg, cnt};
    endfunction

    function automatic logic [27:0] outs_now();
        return {state, mem_re, mem_we, mem_sel, ir_we, pc_we, rf_we,
                illegal, mem_timeout, done, instr_count};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d strb=%b flg=%b cnt=%0d, expected st=%0d strb=%b flg=%b cnt=%0d",
                     name, act[27:25], act[24:19], act[18:16], act[15:0],
                     exp[27:25], exp[24:19], exp[18:16], exp[15:0]);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic [7:0] p, input logic rdy,
                       input logic [2:0] st, input logic [5:0] strb, input logic [2:0] flg,
                       input logic [15:0] cnt);
        vec_t v;
        v.run = r; v.op = op; v.pc = p; v.rdy = rdy;
        v.st = st; v.strb = strb; v.flg = flg; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ir, bad_state;

        // R-type, pc=3 -> back to IF
        add(1'b1, OP_R,    8'd3,  1'b1, S_IF,   6'b100100, 3'b000, 16'd0);
        add(1'b1, OP_R,    8'd3,  1'b1, S_ID,   6'b000000, 3'b000, 16'd0);
        add(1'b1, OP_R,    8'd3,  1'b1, S_EX,   6'b000000, 3'b000, 16'd0);
        add(1'b1, OP_R,    8'd3,  1'b1, S_WB,   6'b000011, 3'b000, 16'd0);
        // lw, mem_ready late by 3 cycles, pc=5
        add(1'b1, OP_LW,   8'd5,  1'b1, S_IF,   6'b100100, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b1, S_ID,   6'b000000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b1, S_EX,   6'b000000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b0, S_MEM,  6'b101000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b0, S_MEM,  6'b101000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b0, S_MEM,  6'b101000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b1, S_MEM,  6'b101000, 3'b000, 16'd1);
        add(1'b1, OP_LW,   8'd5,  1'b1, S_WB,   6'b000011, 3'b000, 16'd1);
        // illegal opcode retires from EX
        add(1'b1, OP_BAD,  8'd4,  1'b1, S_IF,   6'b100100, 3'b000, 16'd2);
        add(1'b1, OP_BAD,  8'd4,  1'b1, S_ID,   6'b000000, 3'b000, 16'd2);
        add(1'b1, OP_BAD,  8'd4,  1'b1, S_EX,   6'b000010, 3'b000, 16'd2);
        // beq; mem_ready in ID/EX is ignored
        add(1'b1, OP_BEQ,  8'd7,  1'b1, S_IF,   6'b100100, 3'b100, 16'd3);
        add(1'b1, OP_BEQ,  8'd7,  1'b0, S_ID,   6'b000000, 3'b100, 16'd3);
        add(1'b1, OP_BEQ,  8'd7,  1'b0, S_EX,   6'b000010, 3'b100, 16'd3);
        // addi with a fetch wait and a run=0 stall, retire at pc=PROG_LEN-1
        add(1'b1, OP_ADDI, 8'd10, 1'b0, S_IF,   6'b100000, 3'b100, 16'd4);
        add(1'b0, OP_ADDI, 8'd10, 1'b1, S_IF,   6'b000000, 3'b100, 16'd4);
        add(1'b1, OP_ADDI, 8'd10, 1'b1, S_IF,   6'b100100, 3'b100, 16'd4);
        add(1'b1, OP_ADDI, 8'd10, 1'b1, S_ID,   6'b000000, 3'b100, 16'd4);
        add(1'b1, OP_ADDI, 8'd10, 1'b1, S_EX,   6'b000000, 3'b100, 16'd4);
        add(1'b1, OP_ADDI, 8'd10, 1'b1, S_WB,   6'b000011, 3'b100, 16'd4);
        // jump
        add(1'b1, OP_J,    8'd10, 1'b1, S_IF,   6'b100100, 3'b100, 16'd5);
        add(1'b1, OP_J,    8'd10, 1'b1, S_ID,   6'b000000, 3'b100, 16'd5);
        add(1'b1, OP_J,    8'd10, 1'b1, S_EX,   6'b000010, 3'b100, 16'd5);
        // sw at pc=PROG_LEN -> HALT with done
        add(1'b1, OP_SW,   8'd11, 1'b1, S_IF,   6'b100100, 3'b100, 16'd6);
        add(1'b1, OP_SW,   8'd11, 1'b1, S_ID,   6'b000000, 3'b100, 16'd6);
        add(1'b1, OP_SW,   8'd11, 1'b0, S_EX,   6'b000000, 3'b100, 16'd6);
        add(1'b1, OP_SW,   8'd11, 1'b0, S_MEM,  6'b011000, 3'b100, 16'd6);
        add(1'b0, OP_SW,   8'd11, 1'b1, S_MEM,  6'b000000, 3'b100, 16'd6);
        add(1'b1, OP_SW,   8'd11, 1'b1, S_MEM,  6'b011010, 3'b100, 16'd6);
        add(1'b1, OP_SW,   8'd11, 1'b1, S_HALT, 6'b000000, 3'b101, 16'd7);
        add(1'b1, OP_R,    8'd3,  1'b1, S_HALT, 6'b000000, 3'b101, 16'd7);

        reset_n = 1'b0; run = 1'b0; opcode = 6'd0; pc = 8'd0; mem_ready = 1'b0;
        @(negedge clk);
        #2 check("reset_state", outs_now(), pack(S_IF, 6'b0, 3'b0, 16'd0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run = vecs[i].run; opcode = vecs[i].op; pc = vecs[i].pc; mem_ready = vecs[i].rdy;
            #2 check($sformatf("vec%0d", i), outs_now(),
                     pack(vecs[i].st, vecs[i].strb, vecs[i].flg, vecs[i].cnt));
            @(negedge clk);
        end

        // Reset out of HALT, then a fetch that never completes
        run = 1'b1; mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("reset_in_halt", outs_now(), pack(S_IF, 6'b0, 3'b0, 16'd0));
        @(negedge clk);
        reset_n = 1'b1;
        saw_ir = 1'b0; bad_state = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #2;
            if (ir_we) saw_ir = 1'b1;
            if (state != S_IF) bad_state = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad_state) begin
            errors++;
            $display("FAIL if_wait_hold: left IF before 15 wait cycles, expected IF throughout");
        end
        checks++;
        if (saw_ir) begin
            errors++;
            $display("FAIL if_wait_ir_we: ir_we=1 seen, expected 0 while mem_ready=0");
        end
        #2 check("if_timeout", outs_now(), pack(S_HALT, 6'b0, 3'b010, 16'd0));
        @(negedge clk);

        // lw stalled in MEM: run=0 freezes state and wait counter
        do_reset();
        run = 1'b1; opcode = OP_LW; pc = 8'd2; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #2 check("mem_entry", outs_now(), pack(S_MEM, 6'b101000, 3'b000, 16'd0));
        repeat (2) @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 check($sformatf("mem_stall%0d", i), outs_now(), pack(S_MEM, 6'b0, 3'b000, 16'd0));
            @(negedge clk);
        end
        run = 1'b1;
        repeat (12) @(negedge clk);
        #2 check("mem_before_timeout", outs_now(), pack(S_MEM, 6'b101000, 3'b000, 16'd0));
        @(negedge clk);
        #2 check("mem_timeout", outs_now(), pack(S_HALT, 6'b0, 3'b010, 16'd0));
        @(negedge clk);

        // Illegal retire, then reset while a store is in MEM
        do_reset();
        run = 1'b1; opcode = OP_BAD; pc = 8'd1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        opcode = OP_SW;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #2 check("sw_in_mem", outs_now(), pack(S_MEM, 6'b011000, 3'b100, 16'd1));
        #1 reset_n = 1'b0;
        #1 check("reset_mid_mem", outs_now(), pack(S_IF, 6'b0, 3'b000, 16'd0));
        @(negedge clk);
        reset_n = 1'b1; opcode = OP_R; mem_ready = 1'b1;
        #2 check("first_edge_if", outs_now(), pack(S_IF, 6'b100100, 3'b000, 16'd0));
        @(negedge clk);
        #2 check("after_release_id", outs_now(), pack(S_ID, 6'b0, 3'b000, 16'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
